// File: rtl/dds_waveform_engine_pkg.sv
// Shared encodings for the DDS waveform engine: shape selects and shadow-load FSM states.
package dds_waveform_engine_pkg;

  localparam int WAVE_SEL_W = 3;

  typedef enum logic [WAVE_SEL_W-1:0] {
    WAVE_SINE   = 3'd0,
    WAVE_TRI    = 3'd1,
    WAVE_SQUARE = 3'd2,
    WAVE_PWM    = 3'd3,
    WAVE_SAW    = 3'd4
  } wave_sel_e;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_PEND = 1'b1
  } ld_state_e;

endpackage

// File: rtl/dds_waveform_engine_if.sv
// Control, sine-ROM and sample bus of the DDS engine; master is the surrounding system.
interface dds_waveform_engine_if
  import dds_waveform_engine_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8
);
  logic                  enable;
  logic                  phase_sync;
  logic [PHASE_W-1:0]    freq_word;
  logic                  load_req;
  logic [WAVE_SEL_W-1:0] wave_sel;
  logic [DATA_W:0]       duty;
  logic [DATA_W-1:0]     amp;
  logic [ADDR_W-1:0]     lut_addr;
  logic [DATA_W-1:0]     lut_data;
  logic                  load_ack;
  logic [DATA_W-1:0]     waveform;
  logic                  sample_valid;

  modport master (
    output enable, phase_sync, freq_word, load_req, wave_sel, duty, amp, lut_data,
    input  lut_addr, load_ack, waveform, sample_valid
  );

  modport slave (
    input  enable, phase_sync, freq_word, load_req, wave_sel, duty, amp, lut_data,
    output lut_addr, load_ack, waveform, sample_valid
  );
endinterface

// File: rtl/dds_waveform_engine_wave_shaper.sv
// Shaping stage: turns the top phase bits (or sine ROM data) into an unscaled sample.
module dds_waveform_engine_wave_shaper
  import dds_waveform_engine_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  vld,
  input  logic [DATA_W:0]       p,
  input  logic [WAVE_SEL_W-1:0] sel,
  input  logic [DATA_W:0]       duty,
  input  logic [DATA_W-1:0]     sine,
  output logic [DATA_W-1:0]     raw
);

  // PWM compares at sample resolution so duty spans 0 (never high) to 2^DATA_W (always high).
  logic pwm_hi;
  assign pwm_hi = ({1'b0, p[DATA_W:1]} < duty);

  always_comb begin
    raw = '0;
    if (vld) begin
      case (sel)
        WAVE_SINE:   raw = sine;
        WAVE_TRI:    raw = {DATA_W{p[DATA_W]}} ^ p[DATA_W-1:0];
        WAVE_SQUARE: raw = {DATA_W{p[DATA_W]}};
        WAVE_PWM:    raw = {DATA_W{pwm_hi}};
        WAVE_SAW:    raw = p[DATA_W:1];
        default:     raw = '0;
      endcase
    end
  end

endmodule

// File: rtl/dds_waveform_engine.sv
// DDS engine top: phase accumulator, glitch-free shadow settings, shaping and amplitude scaling.
module dds_waveform_engine
  import dds_waveform_engine_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dds_waveform_engine_if.slave bus
);

  localparam int STAGES = 2;

  logic [PHASE_W-1:0]    phase;
  logic [PHASE_W:0]      sum;
  logic                  wrap, apply_evt, apply;
  ld_state_e             state, state_nxt;
  logic [WAVE_SEL_W-1:0] sh_sel, act_sel, sel_s1, sel_new;
  logic [DATA_W:0]       sh_duty, act_duty, duty_s1, duty_new;
  logic [DATA_W-1:0]     sh_amp, act_amp, amp_s1, amp_new;
  logic [DATA_W:0]       p_s1;
  logic [STAGES:0]       vld_pipe;
  logic [DATA_W-1:0]     raw, wave_nxt, wave_q;
  logic [DATA_W:0]       gain;
  logic [2*DATA_W:0]     prod;
  logic                  ack;

  assign sum       = {1'b0, phase} + {1'b0, bus.freq_word};
  assign wrap      = bus.enable & sum[PHASE_W];
  assign apply_evt = wrap | bus.phase_sync | ~bus.enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              phase <= '0;
    else if (!bus.enable || bus.phase_sync)  phase <= '0;
    else                                     phase <= sum[PHASE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (apply)             state_nxt = LD_IDLE;
    else if (bus.load_req) state_nxt = LD_PEND;
  end

  // A request landing on the apply cycle bypasses the shadow and goes live at once.
  always_comb begin
    apply    = ((state == LD_PEND) || bus.load_req) && apply_evt;
    sel_new  = bus.load_req ? bus.wave_sel : sh_sel;
    duty_new = bus.load_req ? bus.duty     : sh_duty;
    amp_new  = bus.load_req ? bus.amp      : sh_amp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_sel   <= '0;
      sh_duty  <= '0;
      sh_amp   <= '0;
      act_sel  <= '0;
      act_duty <= '0;
      act_amp  <= '0;
      ack      <= 1'b0;
    end else begin
      if (bus.load_req) begin
        sh_sel  <= bus.wave_sel;
        sh_duty <= bus.duty;
        sh_amp  <= bus.amp;
      end
      if (apply) begin
        act_sel  <= sel_new;
        act_duty <= duty_new;
        act_amp  <= amp_new;
      end
      ack <= apply;
    end
  end

  // Settings travel with the phase sample, so the first wrapped sample is the first in the new mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1     <= '0;
      sel_s1   <= '0;
      duty_s1  <= '0;
      amp_s1   <= '0;
      vld_pipe <= '0;
      wave_q   <= '0;
    end else begin
      p_s1     <= phase[PHASE_W-1 -: DATA_W+1];
      sel_s1   <= act_sel;
      duty_s1  <= act_duty;
      amp_s1   <= act_amp;
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.enable};
      wave_q   <= wave_nxt;
    end
  end

  dds_waveform_engine_wave_shaper #(.DATA_W(DATA_W)) u_shaper (
    .vld  (vld_pipe[1]),
    .p    (p_s1),
    .sel  (sel_s1),
    .duty (duty_s1),
    .sine (bus.lut_data),
    .raw  (raw)
  );

  // Gain (amp+1)/2^DATA_W: full-scale in with amp all-ones comes out full-scale.
  assign gain     = {1'b0, amp_s1} + {{DATA_W{1'b0}}, 1'b1};
  assign prod     = {{(DATA_W+1){1'b0}}, raw} * {{DATA_W{1'b0}}, gain};
  assign wave_nxt = DATA_W'(prod >> DATA_W);

  assign bus.lut_addr     = phase[PHASE_W-1 -: ADDR_W];
  assign bus.load_ack     = ack;
  assign bus.waveform     = wave_q;
  assign bus.sample_valid = vld_pipe[STAGES];

endmodule
